// File: rtl/deadlock_watchdog_ctrl_pkg.sv
// Shared types and default sizing for the deadlock watchdog controller.
package deadlock_ctrl_pkg;

  localparam int unsigned N_MON_DEF = 4;
  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned ID_W_DEF  = 4;

  // Report channel FSM: IDLE picks a pending monitor, SEND holds the report until accepted.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage : deadlock_ctrl_pkg

// File: rtl/deadlock_watchdog_ctrl_if.sv
// Trip report channel: valid/ready handshake carrying the monitor index and captured count.
interface deadlock_watchdog_ctrl_if
  import deadlock_ctrl_pkg::*;
#(
  parameter int unsigned ID_W  = ID_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
);

  logic             report_valid;
  logic             report_ready;
  logic [ID_W-1:0]  report_id;
  logic [CNT_W-1:0] report_cycles;

  modport master (
    output report_valid,
    output report_id,
    output report_cycles,
    input  report_ready
  );

  modport slave (
    input  report_valid,
    input  report_id,
    input  report_cycles,
    output report_ready
  );

endinterface : deadlock_watchdog_ctrl_if

// File: rtl/deadlock_watchdog_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first request strictly after ptr_i, wrapping around.
module rr_arbiter
  import deadlock_ctrl_pkg::*;
#(
  parameter int unsigned N_MON = N_MON_DEF,
  parameter int unsigned ID_W  = ID_W_DEF
) (
  input  logic [N_MON-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_MON-1:0] grant_c,
  output logic [ID_W-1:0]  idx_c,
  output logic             valid_c
);

  // Search the indices above ptr_i first, then wrap to 0..ptr_i.
  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    valid_c = 1'b0;
    for (int k = 0; k < int'(N_MON); k++) begin
      if (!valid_c && req_i[k] && (k > int'(ptr_i))) begin
        valid_c    = 1'b1;
        grant_c[k] = 1'b1;
        idx_c      = ID_W'(k);
      end
    end
    for (int k = 0; k < int'(N_MON); k++) begin
      if (!valid_c && req_i[k] && (k <= int'(ptr_i))) begin
        valid_c    = 1'b1;
        grant_c[k] = 1'b1;
        idx_c      = ID_W'(k);
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/deadlock_watchdog_ctrl.sv
// Qualifies per-monitor deadlock block levels against a persistence threshold,
// serialises trip reports round-robin, and raises a sticky halt request.
module deadlock_watchdog_ctrl
  import deadlock_ctrl_pkg::*;
#(
  parameter int unsigned N_MON = N_MON_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned ID_W  = ID_W_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_MON-1:0]         block_in,
  input  logic [CNT_W-1:0]         threshold,
  input  logic                     enable,
  input  logic                     clear,
  deadlock_watchdog_ctrl_if.master rpt,
  output logic [N_MON-1:0]         tripped_mask,
  output logic                     halt_req
);

  // Count table is sized to the full ID space so the granted index selects it without truncation.
  localparam int unsigned    N_SLOT  = 1 << ID_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ID_W-1:0]  PTR_RST = ID_W'(N_MON - 1);

  logic               thr_on;
  logic [N_MON-1:0]   trip_vec;
  logic [CNT_W-1:0]   cnt_all [N_SLOT];

  logic [N_MON-1:0]   arb_grant;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_valid;
  logic [N_MON-1:0]   grant_clr;

  state_e             state_q, state_d;
  logic               report_valid_q, report_valid_d;
  logic [ID_W-1:0]    report_id_q, report_id_d;
  logic [CNT_W-1:0]   report_cycles_q, report_cycles_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [N_MON-1:0]   pending_q, pending_d;
  logic [N_MON-1:0]   tripped_mask_q, tripped_mask_d;
  logic               halt_req_q, halt_req_d;

  assign thr_on = (threshold != '0);

  // Per-monitor persistence counter and episode arm flag.
  for (genvar i = 0; i < int'(N_MON); i++) begin : g_mon
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;
    logic             hit;

    // Saturating run-length count; trip once per episode when the run reaches threshold.
    always_comb begin
      cnt_d   = '0;
      armed_d = 1'b1;
      hit     = 1'b0;
      if (block_in[i]) begin
        cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        hit     = armed_q && thr_on &&
                  (({1'b0, cnt_q} + (CNT_W + 1)'(1)) >= {1'b0, threshold});
        armed_d = armed_q && !hit;
      end
    end

    // Counter and arm registers.
    always_ff @(posedge clock) begin
      if (reset) begin
        cnt_q   <= '0;
        armed_q <= 1'b1;
      end else begin
        cnt_q   <= cnt_d;
        armed_q <= armed_d;
      end
    end

    assign trip_vec[i] = hit;
    assign cnt_all[i]  = cnt_q;
  end : g_mon

  for (genvar s = int'(N_MON); s < int'(N_SLOT); s++) begin : g_pad
    assign cnt_all[s] = '0;
  end : g_pad

  rr_arbiter #(
    .N_MON (N_MON),
    .ID_W  (ID_W)
  ) u_arb (
    .req_i   (pending_q),
    .ptr_i   (ptr_q),
    .grant_c (arb_grant),
    .idx_c   (arb_idx),
    .valid_c (arb_valid)
  );

  // Report FSM: grant from IDLE captures the live count, SEND holds until accepted.
  always_comb begin
    state_d         = state_q;
    report_valid_d  = report_valid_q;
    report_id_d     = report_id_q;
    report_cycles_d = report_cycles_q;
    ptr_d           = ptr_q;
    grant_clr       = '0;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_clr       = arb_grant;
          report_id_d     = arb_idx;
          report_cycles_d = cnt_all[arb_idx];
          report_valid_d  = 1'b1;
          state_d         = SEND;
        end
      end
      SEND: begin
        if (rpt.report_ready) begin
          ptr_d          = report_id_q;
          report_valid_d = 1'b0;
          state_d        = IDLE;
        end
      end
      default: begin
        report_valid_d = 1'b0;
        state_d        = IDLE;
      end
    endcase
  end

  // Pending/sticky flags: a grant absorbs a same-cycle re-trip; a trip beats clear on the mask.
  always_comb begin
    pending_d      = (pending_q | trip_vec) & ~grant_clr;
    tripped_mask_d = (tripped_mask_q & ~{N_MON{clear}}) | trip_vec;
    halt_req_d     = enable & (|tripped_mask_q);
  end

  // Control and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      report_valid_q  <= 1'b0;
      report_id_q     <= '0;
      report_cycles_q <= '0;
      ptr_q           <= PTR_RST;
      pending_q       <= '0;
      tripped_mask_q  <= '0;
      halt_req_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      report_valid_q  <= report_valid_d;
      report_id_q     <= report_id_d;
      report_cycles_q <= report_cycles_d;
      ptr_q           <= ptr_d;
      pending_q       <= pending_d;
      tripped_mask_q  <= tripped_mask_d;
      halt_req_q      <= halt_req_d;
    end
  end

  assign rpt.report_valid  = report_valid_q;
  assign rpt.report_id     = report_id_q;
  assign rpt.report_cycles = report_cycles_q;
  assign tripped_mask      = tripped_mask_q;
  assign halt_req          = halt_req_q;

endmodule : deadlock_watchdog_ctrl

// File: tb/tb_deadlock_watchdog_ctrl.sv
// Bench for deadlock_watchdog_ctrl: directed scenarios plus random traffic,
// checked against an episode-level reference model via an expected-report queue.
module tb_deadlock_watchdog_ctrl;

  localparam int unsigned N    = 4;
  localparam int unsigned W    = 4;
  localparam int unsigned IDW  = 4;
  localparam int          MAXC = 15;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   blk;
  logic [W-1:0]   thr;
  logic           en;
  logic           clr;
  logic [N-1:0]   mask;
  logic           halt;

  deadlock_watchdog_ctrl_if #(.ID_W(IDW), .CNT_W(W)) rif ();

  deadlock_watchdog_ctrl #(
    .N_MON (N),
    .CNT_W (W),
    .ID_W  (IDW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .block_in     (blk),
    .threshold    (thr),
    .enable       (en),
    .clear        (clr),
    .rpt          (rif.master),
    .tripped_mask (mask),
    .halt_req     (halt)
  );

  always #5 clock = ~clock;

  typedef struct {
    int id;
    int cyc;
  } rep_t;

  rep_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: run lengths are unbounded, episodes are tracked by a reported flag.
  int   run_m   [N];
  bit   done_m  [N];
  bit   pend_m  [N];
  bit   mask_m  [N];
  bit   halt_m;
  bit   busy_m;
  int   cur_m;
  int   last_m;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit any_mask();
    bit a = 1'b0;
    for (int i = 0; i < int'(N); i++) a |= mask_m[i];
    return a;
  endfunction

  function automatic int mask_vec();
    int v = 0;
    for (int i = 0; i < int'(N); i++) if (mask_m[i]) v |= (1 << i);
    return v;
  endfunction

  // Reference model: advances on each clock edge from the inputs applied before it.
  always @(posedge clock) begin
    bit  taken [N];
    bit  new_halt;
    bit  trip;
    int  g;
    int  j;
    int  nr;
    if (reset) begin
      for (int i = 0; i < int'(N); i++) begin
        run_m[i] = 0; done_m[i] = 0; pend_m[i] = 0; mask_m[i] = 0;
      end
      halt_m = 0; busy_m = 0; cur_m = 0; last_m = N - 1;
      exp_q.delete();
    end else begin
      new_halt = en && any_mask();
      for (int i = 0; i < int'(N); i++) taken[i] = 0;
      if (busy_m) begin
        if (rif.report_ready) begin
          busy_m = 0;
          last_m = cur_m;
        end
      end else begin
        g = -1;
        for (int k = 1; k <= int'(N); k++) begin
          j = (last_m + k) % N;
          if (g < 0 && pend_m[j]) g = j;
        end
        if (g >= 0) begin
          rep_t r;
          r.id  = g;
          r.cyc = (run_m[g] > MAXC) ? MAXC : run_m[g];
          exp_q.push_back(r);
          taken[g] = 1;
          busy_m   = 1;
          cur_m    = g;
        end
      end
      for (int i = 0; i < int'(N); i++) begin
        nr   = blk[i] ? run_m[i] + 1 : 0;
        trip = blk[i] && !done_m[i] && (thr != 0) && (nr >= int'(thr));
        done_m[i] = blk[i] && (done_m[i] || trip);
        pend_m[i] = (pend_m[i] || trip) && !taken[i];
        mask_m[i] = trip || (mask_m[i] && !clr);
        run_m[i]  = nr;
      end
      halt_m = new_halt;
    end
  end

  // Acceptance monitor: each handshake consumes one expected report.
  always @(posedge clock) begin
    if (!reset && rif.report_valid && rif.report_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL accept_unexpected: got id %0d cycles %0d expected no report at %0t",
                 rif.report_id, rif.report_cycles, $time);
      end else begin
        chk("accept_id", int'(rif.report_id), exp_q[0].id);
        chk("accept_cycles", int'(rif.report_cycles), exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  // Per-cycle output check just after each edge, including hold stability under backpressure.
  always @(posedge clock) begin
    #1;
    chk("report_valid", int'(rif.report_valid), int'(busy_m));
    chk("tripped_mask", int'(mask), mask_vec());
    chk("halt_req", int'(halt), int'(halt_m));
    if (rif.report_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL hold_unexpected: got id %0d expected empty queue at %0t",
                 rif.report_id, $time);
      end else begin
        chk("hold_id", int'(rif.report_id), exp_q[0].id);
        chk("hold_cycles", int'(rif.report_cycles), exp_q[0].cyc);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish by 200000");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    reset = 1'b1; blk = '0; thr = 4'd5; en = 1'b1; clr = 1'b0;
    rif.report_ready = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(2);

    // Persistence: a 4-cycle stall is ignored, a 5-cycle stall trips monitor 2.
    blk = 4'b0100; cyc(4); blk = '0; cyc(3);
    blk = 4'b0100; cyc(5); blk = '0; cyc(6);
    clr = 1'b1; cyc(1); clr = 1'b0; cyc(2);

    // Simultaneous trip of all monitors drains round-robin.
    thr = 4'd3; blk = 4'b1111; cyc(15); blk = '0; cyc(3);

    // Backpressure on id 1 while 0 and 2 become pending.
    rif.report_ready = 1'b0;
    blk = 4'b0010; cyc(3); blk = 4'b0101; cyc(4); blk = '0; cyc(10);
    rif.report_ready = 1'b1; cyc(8);

    // Saturation: id 0 waits behind a held report until its count pins at 15.
    rif.report_ready = 1'b0;
    blk = 4'b1000; cyc(3); blk = 4'b0001; cyc(25);
    rif.report_ready = 1'b1; cyc(15);
    blk = '0; cyc(1); blk = 4'b0001; cyc(3); blk = '0; cyc(5);

    // Clear collides with a new trip of bit 3; then clear alone; then enable gating.
    blk = 4'b1000; cyc(2); clr = 1'b1; cyc(1); clr = 1'b0; blk = '0; cyc(3);
    clr = 1'b1; cyc(1); clr = 1'b0; cyc(3);
    en = 1'b0; blk = 4'b0110; cyc(5); blk = '0; cyc(6);
    en = 1'b1; cyc(3);
    clr = 1'b1; cyc(1); clr = 1'b0; cyc(2);

    // Zero threshold disables tripping; lowering it below the live count trips next cycle.
    thr = 4'd0; blk = 4'b1111; cyc(100);
    thr = 4'd2; cyc(10);
    blk = '0; thr = 4'd3; cyc(12);

    // Reset while a report is held in SEND.
    rif.report_ready = 1'b0;
    blk = 4'b0100; cyc(3); blk = '0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      cyc(1);
      seen = rif.report_valid;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL send_before_reset: got no report_valid expected report_valid within 10 cycles");
    end
    reset = 1'b1; cyc(1); reset = 1'b0; cyc(2);
    rif.report_ready = 1'b1; cyc(2);

    // Random traffic.
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < int'(N); i++)
        if ($urandom_range(0, 5) == 0) blk[i] = ~blk[i];
      if ($urandom_range(0, 39) == 0) thr = W'($urandom_range(0, 6));
      rif.report_ready = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) en = ~en;
      cyc(1);
    end

    // Drain and confirm every expected report was delivered.
    blk = '0; clr = 1'b0; en = 1'b1; rif.report_ready = 1'b1;
    cyc(20);
    chk("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_deadlock_watchdog_ctrl

// File: doc/deadlock_watchdog_ctrl.md
Name: deadlock_watchdog_ctrl

Overview:
- Supervises the per-instance HLS deadlock monitors of the fake-trigger kernel; each monitor drives a 1-bit `block` level.
- Qualifies each block level with a programmable persistence threshold, so that short AXIS stalls are ignored.
- Serialises trip reports from all monitors onto one valid/ready report channel using a round-robin arbiter.
- Raises a sticky halt request to the kernel sequencer. The block sits between the monitors and the control/status AXI-Lite register file.

Parameters:
- N_MON, 4, number of monitored block inputs (2..16).
- CNT_W, 16, width of the persistence counters and threshold.
- ID_W, 4, width of the report channel ID; must satisfy 2^ID_W >= N_MON.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- block_in  in  N_MON  level block flags from the deadlock monitors; bit i belongs to monitor i.
- threshold  in  CNT_W  consecutive block cycles needed to trip; 0 disables all tripping.
- enable  in  1  gates the halt_req output only.
- clear  in  1  single-cycle pulse; clears tripped_mask and halt_req.
- report_valid  out  1  a report is presented.
- report_ready  in  1  the consumer accepts the report.
- report_id  out  ID_W  index of the tripped monitor.
- report_cycles  out  CNT_W  counter value captured at grant.
- tripped_mask  out  N_MON  sticky per-monitor trip flags.
- halt_req  out  1  registered halt request: enable & |tripped_mask.

Behaviour:
- Reset values:
  - All outputs 0.
  - Counters 0, pending 0.
  - armed all 1.
  - Round-robin pointer = N_MON-1, so that monitor 0 has first priority.
  - FSM in IDLE.
- Per-monitor counter i:
  - block_in[i]=0: cnt<=0 and armed<=1.
  - block_in[i]=1: cnt<=cnt+1, saturating at 2^CNT_W-1. No wrap.
- Trip condition: block_in[i]=1 and armed[i]=1 and threshold!=0 and (cnt+1)>=threshold. On trip:
  - pending[i]<=1, armed[i]<=0, tripped_mask[i]<=1.
  - Result: exactly one report per continuous block episode. The first trip occurs in the cycle when block_in has been high for `threshold` cycles.
- tripped_mask set/clear: set has priority over clear in the same cycle for the same bit. clear never affects pending, armed or the counters.
- halt_req timing: registered, so it follows tripped_mask and enable with 1 cycle of latency.
- FSM state IDLE:
  - If |pending, grant the first pending index searching upward from ptr+1, with wrap-around.
  - On grant, load report_id=g and report_cycles=cnt[g] (current value).
  - In the same cycle, clear pending[g] and go to SEND.
  - If pending[g] is being set in the same cycle, the grant sees it on the next cycle.
- FSM state SEND:
  - report_valid=1; report_id and report_cycles are held stable.
  - When report_ready=1: ptr<=report_id, report_valid<=0, go to IDLE.
  - report_valid must not drop without acceptance.
- Throughput: at most one report every 2 cycles, because of the IDLE turnaround.
- Pending limit: a monitor that re-trips while its previous report is still queued cannot create a second pending. It cannot re-arm until block_in drops, and re-arming requires that drop.
- Threshold changes mid-operation: take effect on the next compare. A lowered threshold at or below the current cnt trips on the next cycle if the monitor is armed.
- report_ready outside SEND is ignored.
- Reset mid-SEND: the report is dropped; all state returns to reset values.

Decomposition:
- Shared package `deadlock_ctrl_pkg` contains:
  - the FSM state enum (IDLE, SEND);
  - default constants for N_MON, CNT_W and ID_W.
- One natural sub-module, `rr_arbiter`: N_MON request vector plus pointer in; one-hot grant and index out. It is purely combinational and reused for each grant decision.
- Per-monitor counter/arm logic is a generate loop, not a separate module.

Test Plan:
- Persistence, basic trip: threshold=5; block_in[2] high for 4 cycles then low → no trip. Then high for 5 cycles → tripped_mask=0b0100; report_valid with id=2, cycles=5; halt_req=1 one cycle later (enable=1).
- Round-robin on simultaneous trip: threshold=3, report_ready=1; block_in=0b1111 raised together → reports with ids 0, 1, 2, 3 in order, each valid for 1 cycle and separated by a 1-cycle gap. No duplicates while block_in is held high.
- Backpressure: report_ready=0 for 10 cycles after a trip of id 1 → report_valid, id=1 and cycles held constant. Release ready → accepted once, and the next grant starts from id 2.
- Episode re-arm and saturation: CNT_W=4, threshold=3, block_in[0] held high for 40 cycles → exactly one report and cnt saturates at 15. Drop for 1 cycle, raise for 3 cycles → second report.
- Clear/set collision and gating:
  - clear asserted in the same cycle as a new trip of bit 3 → tripped_mask[3]=1.
  - clear alone → mask 0 and halt_req 0 the next cycle.
  - enable=0 → halt_req stays 0 despite trips.
- Disable and reset: threshold=0 with block_in all high for 100 cycles → no reports. Reset asserted while in SEND → report_valid=0 on the next cycle and all state returns to reset values.
